// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider.
// Each channel produces a registered divided clock with independently
// programmable high and low phase lengths. Divide values are sampled only
// when a period starts, so a reload never produces a runt pulse. A common
// sync_start pulse restarts every enabled channel in phase.
module clock_divider_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    inclk,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync_start,
  input  logic [NUM_CH*CNT_W-1:0] high_count,
  input  logic [NUM_CH*CNT_W-1:0] low_count,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_Not,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] hi_q, hi_d;
      logic [CNT_W-1:0] lo_q, lo_d;
      logic [CNT_W-1:0] hc, lc;
      logic             load;
      logic             oc_q, oc_d;
      logic             tk_q, tk_d;
      logic             ac_q, ac_d;

      assign hc = high_count[g*CNT_W +: CNT_W];
      assign lc = low_count[g*CNT_W +: CNT_W];

      // Next-state logic: phase counting, period-boundary reload, sync restart.
      // A load always lands in HIGH with the counter cleared, so the registered
      // outputs are derived from the next state rather than the current one.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;

        if (sync_start && en[g]) begin
          load = 1'b1;
        end else begin
          case (state_q)
            HIGH: begin
              if (cnt_q == hi_q - ONE) begin
                cnt_d   = '0;
                state_d = LOW;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
            LOW: begin
              if (cnt_q == lo_q - ONE) begin
                if (en[g]) begin
                  load = 1'b1;
                end else begin
                  cnt_d   = '0;
                  state_d = IDLE;
                end
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
            default: begin
              cnt_d   = '0;
              state_d = IDLE;
              if (en[g]) load = 1'b1;
            end
          endcase
        end

        if (load) begin
          hi_d    = (hc == '0) ? ONE : hc;
          lo_d    = (lc == '0) ? ONE : lc;
          cnt_d   = '0;
          state_d = HIGH;
        end

        oc_d = (state_d == HIGH);
        tk_d = load;
        ac_d = (state_d != IDLE);
      end

      // State, counter, shadow and output registers with synchronous reset.
      always_ff @(posedge inclk) begin
        if (Reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          hi_q    <= ONE;
          lo_q    <= ONE;
          oc_q    <= 1'b0;
          tk_q    <= 1'b0;
          ac_q    <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          oc_q    <= oc_d;
          tk_q    <= tk_d;
          ac_q    <= ac_d;
        end
      end

      assign outclk[g]     = oc_q;
      assign outclk_Not[g] = ~oc_q;
      assign tick[g]       = tk_q;
      assign active[g]     = ac_q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_mc.sv
// Bench for clock_divider_mc (4 channels, 8-bit counts).
module tb_clock_divider_mc;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int BIG = 1 << 30;

  logic            inclk;
  logic            Reset;
  logic [NCH-1:0]  en;
  logic            sync_start;
  logic [NCH*CW-1:0] high_count;
  logic [NCH*CW-1:0] low_count;
  logic [NCH-1:0]  outclk;
  logic [NCH-1:0]  outclk_Not;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  active;

  clock_divider_mc #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .inclk      (inclk),
    .Reset      (Reset),
    .en         (en),
    .sync_start (sync_start),
    .high_count (high_count),
    .low_count  (low_count),
    .outclk     (outclk),
    .outclk_Not (outclk_Not),
    .tick       (tick),
    .active     (active)
  );

  initial begin
    inclk = 1'b0;
    forever #5 inclk = ~inclk;
  end

  typedef struct {
    logic [NCH-1:0] oc;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] ac;
  } exp_t;

  typedef struct {
    logic [CW-1:0] hc;
    logic [CW-1:0] lc;
    int            ehi;
    int            elo;
    int            ncyc;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  // Waveform model: channel c started its current period pattern at sample
  // st[c], repeats eh/el phases, and is idle from sample stop[c] onward.
  int st[NCH];
  int eh[NCH];
  int el[NCH];
  int stop[NCH];

  function automatic exp_t fexp(input int s);
    exp_t e;
    e.oc = '0;
    e.tk = '0;
    e.ac = '0;
    for (int c = 0; c < NCH; c++) begin
      if (st[c] >= 0 && s >= st[c] && s < stop[c]) begin
        int k;
        k = (s - st[c]) % (eh[c] + el[c]);
        e.oc[c] = (k < eh[c]);
        e.tk[c] = (k == 0);
        e.ac[c] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step(input string tag);
    exp_t e;
    sbq.push_back(fexp(t + 1));
    @(posedge inclk);
    #1;
    t++;
    e = sbq.pop_front();
    checks++;
    if (outclk !== e.oc || outclk_Not !== ~e.oc || tick !== e.tk || active !== e.ac) begin
      failures++;
      $display("FAIL %s sample=%0d outclk=%b exp=%b outclk_Not=%b tick=%b exp=%b active=%b exp=%b",
               tag, t, outclk, e.oc, outclk_Not, tick, e.tk, active, e.ac);
    end
  endtask

  task automatic set_cnt(input int c, input logic [CW-1:0] h, input logic [CW-1:0] l);
    high_count[c*CW +: CW] = h;
    low_count[c*CW +: CW]  = l;
  endtask

  task automatic do_reset(input int n, input logic [NCH-1:0] en_after);
    Reset      = 1'b1;
    en         = '1;
    sync_start = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      st[c]   = -1;
      stop[c] = BIG;
    end
    repeat (n) step("reset");
    Reset = 1'b0;
    en    = en_after;
    for (int c = 0; c < NCH; c++)
      if (en_after[c]) st[c] = t + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sample=%0d exp=finished", t);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    en         = '1;
    sync_start = 1'b0;
    high_count = '0;
    low_count  = '0;
    for (int c = 0; c < NCH; c++) begin
      st[c] = -1; eh[c] = 1; el[c] = 1; stop[c] = BIG;
    end

    tbl[0] = '{hc: 8'd2,   lc: 8'd3,   ehi: 2,   elo: 3,   ncyc: 15};
    tbl[1] = '{hc: 8'd0,   lc: 8'd0,   ehi: 1,   elo: 1,   ncyc: 8};
    tbl[2] = '{hc: 8'd1,   lc: 8'd1,   ehi: 1,   elo: 1,   ncyc: 6};
    tbl[3] = '{hc: 8'd3,   lc: 8'd1,   ehi: 3,   elo: 1,   ncyc: 8};
    tbl[4] = '{hc: 8'd255, lc: 8'd1,   ehi: 255, elo: 1,   ncyc: 520};
    tbl[5] = '{hc: 8'd1,   lc: 8'd255, ehi: 1,   elo: 255, ncyc: 260};

    // Table: channel 0 free-running from reset release
    for (int i = 0; i < 6; i++) begin
      set_cnt(0, tbl[i].hc, tbl[i].lc);
      eh[0] = tbl[i].ehi;
      el[0] = tbl[i].elo;
      do_reset(3, 4'b0001);
      repeat (tbl[i].ncyc) step("table_ch0");
    end

    // ch1 4/4, reprogram to 1/7 mid-HIGH: takes effect next period
    set_cnt(1, 8'd4, 8'd4);
    eh[1] = 4; el[1] = 4;
    do_reset(1, 4'b0010);
    repeat (2) step("reload_cur");
    set_cnt(1, 8'd1, 8'd7);
    repeat (6) step("reload_cur");
    st[1] = st[1] + 8; eh[1] = 1; el[1] = 7;
    repeat (16) step("reload_next");

    // ch2 3/3, en dropped in 2nd HIGH cycle: period completes, then idle
    set_cnt(2, 8'd3, 8'd3);
    eh[2] = 3; el[2] = 3;
    do_reset(1, 4'b0100);
    repeat (2) step("clean_stop");
    en[2]   = 1'b0;
    stop[2] = st[2] + 6;
    repeat (10) step("clean_stop");

    // Out-of-phase channels, then sync_start aligns enabled ones
    set_cnt(0, 8'd5, 8'd5); eh[0] = 5; el[0] = 5;
    set_cnt(1, 8'd2, 8'd6); eh[1] = 2; el[1] = 6;
    set_cnt(2, 8'd3, 8'd3); eh[2] = 3; el[2] = 3;
    set_cnt(3, 8'd7, 8'd1); eh[3] = 7; el[3] = 1;
    do_reset(1, 4'b0001);
    repeat (3) step("stagger");
    en[1] = 1'b1; st[1] = t + 1;
    repeat (3) step("stagger");
    en[3] = 1'b1; st[3] = t + 1;
    repeat (6) step("stagger");
    sync_start = 1'b1;
    st[0] = t + 1; st[1] = t + 1; st[3] = t + 1;
    step("sync_start");
    sync_start = 1'b0;
    repeat (7) step("after_sync");

    // Sample 7 after sync: every running channel is in LOW
    Reset = 1'b1;
    for (int c = 0; c < NCH; c++) st[c] = -1;
    repeat (2) step("reset_mid_low");
    Reset = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (en[c]) st[c] = t + 1;
    repeat (6) step("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
